reorder_buffer: RTL and testbench

//   Parametrised in-order-commit reorder buffer for the out-of-order RV32I core.
//   - Allocates entries from the decoder and answers operand lookups for the decoder.
//   - Collects results from NUM_WB writeback channels (ALU, LSB, ...).
//   - Commits at most one entry per cycle to the regfile, LSB and predictor.
//   - Detects branch mispredicts at commit and self-flushes.

---
 rtl/rob_pkg.sv | 30 +++
 rtl/reorder_buffer_if.sv | 54 +++++
 rtl/rob_wb_merge.sv | 33 +++
 rtl/reorder_buffer.sv | 155 +++++++++++++++
 tb/tb_reorder_buffer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared types and defaults for the reorder buffer slice.
// Optional feature macro used by the top: ROB_BYPASS_EN.
package rob_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_TAG_W  = 4;
  localparam int ROB_NUM_WB = 2;

  localparam int ROB_TYPE_W = 2;
  localparam int ROB_RD_W   = 5;
  localparam int ROB_XLEN   = 32;

  typedef enum logic [ROB_TYPE_W-1:0] {
    ROB_T_REG    = 2'b00,
    ROB_T_STORE  = 2'b01,
    ROB_T_BRANCH = 2'b10
  } rob_type_e;

  typedef struct packed {
    logic                valid;
    logic                ready;
    rob_type_e           typ;
    logic [ROB_RD_W-1:0] rd;
    logic [ROB_XLEN-1:0] pc;
    logic                pred;
    logic                jump;
    logic [ROB_XLEN-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Decoder / writeback / commit bus of the reorder buffer.
// master = core side driving requests, slave = the reorder buffer.
interface reorder_buffer_if
  import rob_pkg::*;
#(
  parameter int TAG_W  = ROB_TAG_W,
  parameter int NUM_WB = ROB_NUM_WB
);
  logic                alloc_valid;
  logic [1:0]          alloc_type;
  logic [4:0]          alloc_rd;
  logic [31:0]         alloc_pc;
  logic                alloc_pred;
  logic                alloc_ready;
  logic [31:0]         alloc_value;
  logic [TAG_W-1:0]    alloc_tag;
  logic                full;
  logic                empty;
  logic [TAG_W-1:0]    rs1_tag;
  logic [TAG_W-1:0]    rs2_tag;
  logic [31:0]         rs1_value;
  logic [31:0]         rs2_value;
  logic                rs1_ready;
  logic                rs2_ready;
  logic [NUM_WB-1:0]   wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic [NUM_WB*32-1:0]    wb_value;
  logic [NUM_WB-1:0]   wb_jump;
  logic                commit_valid;
  logic [TAG_W-1:0]    commit_tag;
  logic [1:0]          commit_type;
  logic [4:0]          commit_rd;
  logic [31:0]         commit_value;
  logic [31:0]         commit_pc;
  logic                commit_jump;
  logic                mispredict;
  logic [31:0]         redirect_pc;

  modport master (
    output alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_pred, alloc_ready, alloc_value,
    output rs1_tag, rs2_tag, wb_valid, wb_tag, wb_value, wb_jump,
    input  alloc_tag, full, empty, rs1_value, rs2_value, rs1_ready, rs2_ready,
    input  commit_valid, commit_tag, commit_type, commit_rd, commit_value, commit_pc,
    input  commit_jump, mispredict, redirect_pc
  );

  modport slave (
    input  alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_pred, alloc_ready, alloc_value,
    input  rs1_tag, rs2_tag, wb_valid, wb_tag, wb_value, wb_jump,
    output alloc_tag, full, empty, rs1_value, rs2_value, rs1_ready, rs2_ready,
    output commit_valid, commit_tag, commit_type, commit_rd, commit_value, commit_pc,
    output commit_jump, mispredict, redirect_pc
  );
endinterface

// File: rtl/rob_wb_merge.sv
// Reduces NUM_WB writeback channels to per-entry write enables/data.
// A higher channel index overrides a lower one hitting the same tag.
module rob_wb_merge
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int NUM_WB = ROB_NUM_WB
) (
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic [NUM_WB*32-1:0]    wb_value,
  input  logic [NUM_WB-1:0]       wb_jump,
  output logic [DEPTH-1:0]        we,
  output logic [ROB_XLEN-1:0]     value [DEPTH],
  output logic [DEPTH-1:0]        jump
);

  // Ascending channel scan: later (higher) channels overwrite earlier hits.
  always_comb begin
    we   = '0;
    jump = '0;
    for (int unsigned i = 0; i < DEPTH; i++) value[i] = '0;
    for (int unsigned c = 0; c < NUM_WB; c++) begin
      if (wb_valid[c]) begin
        we[wb_tag[c*TAG_W +: TAG_W]]    = 1'b1;
        value[wb_tag[c*TAG_W +: TAG_W]] = wb_value[c*32 +: 32];
        jump[wb_tag[c*TAG_W +: TAG_W]]  = wb_jump[c];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: allocate, writeback, single commit per
// cycle, self-flush on branch mispredict.
// Optional macro ROB_BYPASS_EN: operand lookups also forward same-cycle writebacks.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int NUM_WB = ROB_NUM_WB
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  input logic             flush,
  reorder_buffer_if.slave bus
);

  localparam int CNT_W = TAG_W + 1;

  rob_entry_t        ent [DEPTH];
  logic [TAG_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, count_next;
  logic              full_q, empty_q;

  logic              c_valid, c_jump, mis_q;
  logic [TAG_W-1:0]  c_tag;
  logic [1:0]        c_type;
  logic [4:0]        c_rd;
  logic [31:0]       c_value, c_pc, redirect_q;

  rob_entry_t        head_ent;
  logic              commit_fire, mis_fire, alloc_fire;

  logic [DEPTH-1:0]  wb_we, wb_jmp;
  logic [31:0]       wb_val [DEPTH];

  // Writebacks are not applied while stalled, so the merge only sees them when rdy=1.
  rob_wb_merge #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WB(NUM_WB)) u_wb_merge (
    .wb_valid (bus.wb_valid & {NUM_WB{rdy}}),
    .wb_tag   (bus.wb_tag),
    .wb_value (bus.wb_value),
    .wb_jump  (bus.wb_jump),
    .we       (wb_we),
    .value    (wb_val),
    .jump     (wb_jmp)
  );

  // Commit/alloc decisions and next occupancy from stored state.
  always_comb begin
    head_ent    = ent[head];
    commit_fire = head_ent.valid && head_ent.ready;
    mis_fire    = commit_fire && (head_ent.typ == ROB_T_BRANCH) && (head_ent.pred != head_ent.jump);
    alloc_fire  = bus.alloc_valid && !full_q;
    count_next  = count + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
  end

  // Operand lookups; stored state, plus same-cycle writeback when bypass is built in.
  always_comb begin
    bus.rs1_ready = ent[bus.rs1_tag].valid && ent[bus.rs1_tag].ready;
    bus.rs1_value = ent[bus.rs1_tag].value;
    bus.rs2_ready = ent[bus.rs2_tag].valid && ent[bus.rs2_tag].ready;
    bus.rs2_value = ent[bus.rs2_tag].value;
`ifdef ROB_BYPASS_EN
    if (ent[bus.rs1_tag].valid && wb_we[bus.rs1_tag]) begin
      bus.rs1_ready = 1'b1;
      bus.rs1_value = wb_val[bus.rs1_tag];
    end
    if (ent[bus.rs2_tag].valid && wb_we[bus.rs2_tag]) begin
      bus.rs2_ready = 1'b1;
      bus.rs2_value = wb_val[bus.rs2_tag];
    end
`endif
  end

  // Entry array, pointers, occupancy flags and registered commit outputs.
  // A mispredicting commit still presents its outputs while the array empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0; tail <= '0; count <= '0;
      full_q <= 1'b0; empty_q <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].ready <= 1'b0;
      end
      c_valid <= 1'b0; c_tag <= '0; c_type <= '0; c_rd <= '0;
      c_value <= '0; c_pc <= '0; c_jump <= 1'b0;
      mis_q <= 1'b0; redirect_q <= '0;
    end else if (!rdy) begin
      c_valid <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      c_valid <= commit_fire && !flush;
      mis_q   <= mis_fire && !flush;
      if (flush) begin
        c_tag <= '0; c_type <= '0; c_rd <= '0;
        c_value <= '0; c_pc <= '0; c_jump <= 1'b0;
        redirect_q <= '0;
      end else if (commit_fire) begin
        c_tag   <= head;
        c_type  <= head_ent.typ;
        c_rd    <= head_ent.rd;
        c_value <= head_ent.value;
        c_pc    <= head_ent.pc;
        c_jump  <= head_ent.jump;
        if (mis_fire) redirect_q <= head_ent.value;
      end

      if (flush || mis_fire) begin
        head <= '0; tail <= '0; count <= '0;
        full_q <= 1'b0; empty_q <= 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          ent[i].valid <= 1'b0;
          ent[i].ready <= 1'b0;
        end
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (wb_we[i] && ent[i].valid) begin
            ent[i].ready <= 1'b1;
            ent[i].value <= wb_val[i];
            ent[i].jump  <= wb_jmp[i];
          end
        end
        if (commit_fire) begin
          ent[head].valid <= 1'b0;
          ent[head].ready <= 1'b0;
          head <= head + TAG_W'(1);
        end
        if (alloc_fire) begin
          ent[tail] <= '{valid: 1'b1, ready: bus.alloc_ready,
                         typ: rob_type_e'(bus.alloc_type), rd: bus.alloc_rd,
                         pc: bus.alloc_pc, pred: bus.alloc_pred, jump: 1'b0,
                         value: bus.alloc_value};
          tail <= tail + TAG_W'(1);
        end
        count   <= count_next;
        full_q  <= (count_next == CNT_W'(DEPTH));
        empty_q <= (count_next == '0);
      end
    end
  end

  assign bus.alloc_tag    = tail;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.commit_valid = c_valid;
  assign bus.commit_tag   = c_tag;
  assign bus.commit_type  = c_type;
  assign bus.commit_rd    = c_rd;
  assign bus.commit_value = c_value;
  assign bus.commit_pc    = c_pc;
  assign bus.commit_jump  = c_jump;
  assign bus.mispredict   = mis_q;
  assign bus.redirect_pc  = redirect_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table, directed corner
// sequences, and randomized traffic against a queue-based program-order model.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, flush;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  reorder_buffer_if #(.TAG_W(4), .NUM_WB(2)) bus ();

  reorder_buffer #(.DEPTH(16), .TAG_W(4), .NUM_WB(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0;
    bus.alloc_valid = 1'b0; bus.alloc_type = 2'b00; bus.alloc_rd = '0;
    bus.alloc_pc = '0; bus.alloc_pred = 1'b0; bus.alloc_ready = 1'b0; bus.alloc_value = '0;
    bus.rs1_tag = '0; bus.rs2_tag = '0;
    bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_value = '0; bus.wb_jump = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                       input logic pred, input logic ardy, input logic [31:0] val);
    bus.alloc_valid = 1'b1; bus.alloc_type = t; bus.alloc_rd = rd;
    bus.alloc_pc = pc; bus.alloc_pred = pred; bus.alloc_ready = ardy; bus.alloc_value = val;
  endtask

  task automatic wb(input int ch, input logic [3:0] tag, input logic [31:0] val, input logic jmp);
    bus.wb_valid[ch] = 1'b1;
    bus.wb_tag[ch*4 +: 4] = tag;
    bus.wb_value[ch*32 +: 32] = val;
    bus.wb_jump[ch] = jmp;
  endtask

  // One row = one clock: stimulus, then expected outputs after the edge.
  typedef struct {
    bit          av;
    bit          ardy;
    logic [31:0] aval;
    bit          wv;
    logic [3:0]  wtag;
    logic [31:0] wval;
    logic [3:0]  e_tag;
    bit          e_empty;
    bit          e_cv;
    logic [3:0]  e_ctag;
    logic [31:0] e_cval;
  } vec_t;

  // Program-order model entry.
  typedef struct {
    int          tag;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    bit          pred;
    bit          done;
    logic [31:0] val;
    bit          jump;
  } ment_t;

  ment_t q[$];
  int    ntag;

  task automatic model_lookup(input logic [3:0] tag, output bit r, output logic [31:0] v);
    bit found;
    found = 1'b0; r = 1'b0; v = '0;
    foreach (q[k]) begin
      if (q[k].tag == int'(tag)) begin
        found = 1'b1;
        r = q[k].done;
        v = q[k].val;
      end
    end
`ifdef ROB_BYPASS_EN
    if (found && rdy) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (bus.wb_valid[ch] && bus.wb_tag[ch*4 +: 4] == tag) begin
          r = 1'b1;
          v = bus.wb_value[ch*32 +: 32];
        end
      end
    end
`endif
  endtask

  vec_t tbl[12];

  initial begin
    rst = 1'b1;
    idle();

    // ---------------- reset state ----------------
    do_reset();
    chk("reset_empty", 32'(bus.empty), 1);
    chk("reset_full", 32'(bus.full), 0);
    chk("reset_alloc_tag", 32'(bus.alloc_tag), 0);
    chk("reset_commit_valid", 32'(bus.commit_valid), 0);
    chk("reset_mispredict", 32'(bus.mispredict), 0);
    chk("reset_redirect", bus.redirect_pc, 0);

    // ---------------- table: alloc / out-of-order wb / in-order commit ----------------
    tbl[0]  = '{1, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0,        0, 0, 0,        2, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0,        0, 0, 0,        3, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0,        1, 1, 32'h22,   3, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0,        1, 0, 32'h11,   3, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0,        0, 0, 0,        3, 0, 1, 0, 32'h11};
    tbl[6]  = '{0, 0, 0,        0, 0, 0,        3, 0, 1, 1, 32'h22};
    tbl[7]  = '{0, 0, 0,        0, 0, 0,        3, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0,        1, 2, 32'h33,   3, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0,        0, 0, 0,        3, 1, 1, 2, 32'h33};
    tbl[10] = '{1, 1, 32'h44,   0, 0, 0,        4, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0,        0, 0, 0,        4, 1, 1, 3, 32'h44};
    foreach (tbl[i]) begin
      idle();
      if (tbl[i].av) alloc(ROB_T_REG, 5'(i + 1), 32'(i * 4), 1'b0, tbl[i].ardy, tbl[i].aval);
      if (tbl[i].wv) wb(0, tbl[i].wtag, tbl[i].wval, 1'b0);
      step();
      chk($sformatf("tbl%0d_alloc_tag", i), 32'(bus.alloc_tag), 32'(tbl[i].e_tag));
      chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_commit_valid", i), 32'(bus.commit_valid), 32'(tbl[i].e_cv));
      if (tbl[i].e_cv) begin
        chk($sformatf("tbl%0d_commit_tag", i), 32'(bus.commit_tag), 32'(tbl[i].e_ctag));
        chk($sformatf("tbl%0d_commit_value", i), bus.commit_value, tbl[i].e_cval);
      end
    end

    // ---------------- fill to full, drop while full, wrap ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle();
      alloc(ROB_T_REG, 5'(i), 32'(i), 1'b0, 1'b0, 32'h0);
      step();
      if (i == 14) chk("fill15_full", 32'(bus.full), 0);
    end
    chk("fill16_full", 32'(bus.full), 1);
    chk("fill16_alloc_tag", 32'(bus.alloc_tag), 0);
    idle();
    alloc(ROB_T_REG, 5'd31, 32'h0, 1'b0, 1'b1, 32'hDEAD);
    step();
    chk("drop17_full", 32'(bus.full), 1);
    chk("drop17_alloc_tag", 32'(bus.alloc_tag), 0);
    idle();
    wb(0, 4'd0, 32'hA0, 1'b0);
    wb(1, 4'd1, 32'hA1, 1'b0);
    step();
    chk("full_wb_commit_valid", 32'(bus.commit_valid), 0);
    idle();
    alloc(ROB_T_REG, 5'd20, 32'h0, 1'b0, 1'b1, 32'hBB);   // full this cycle: dropped
    step();
    chk("full_commit0_valid", 32'(bus.commit_valid), 1);
    chk("full_commit0_value", bus.commit_value, 32'hA0);
    chk("full_commit0_full", 32'(bus.full), 0);
    chk("full_commit0_alloc_tag", 32'(bus.alloc_tag), 0);
    idle();
    alloc(ROB_T_REG, 5'd21, 32'h0, 1'b0, 1'b1, 32'hCC);   // lands at wrapped tag 0
    step();
    chk("wrap_commit1_tag", 32'(bus.commit_tag), 1);
    chk("wrap_commit1_value", bus.commit_value, 32'hA1);
    chk("wrap_full", 32'(bus.full), 0);
    chk("wrap_alloc_tag", 32'(bus.alloc_tag), 1);
    idle();
    bus.rs1_tag = 4'd0;
    #1;
    chk("wrap_lookup_ready", 32'(bus.rs1_ready), 1);
    chk("wrap_lookup_value", bus.rs1_value, 32'hCC);

    // ---------------- branch mispredict ----------------
    do_reset();
    alloc(ROB_T_BRANCH, 5'd0, 32'h100, 1'b0, 1'b0, 32'h0);
    step();
    idle();
    alloc(ROB_T_REG, 5'd5, 32'h104, 1'b0, 1'b1, 32'h55);
    step();
    idle();
    wb(0, 4'd0, 32'h200, 1'b1);
    step();
    idle();
    alloc(ROB_T_REG, 5'd6, 32'h108, 1'b0, 1'b1, 32'h66);   // discarded by the flush
    step();
    chk("br_commit_valid", 32'(bus.commit_valid), 1);
    chk("br_commit_type", 32'(bus.commit_type), 2);
    chk("br_commit_pc", bus.commit_pc, 32'h100);
    chk("br_commit_jump", 32'(bus.commit_jump), 1);
    chk("br_mispredict", 32'(bus.mispredict), 1);
    chk("br_redirect", bus.redirect_pc, 32'h200);
    chk("br_empty", 32'(bus.empty), 1);
    chk("br_alloc_tag", 32'(bus.alloc_tag), 0);
    idle();
    step();
    chk("br_after_mispredict", 32'(bus.mispredict), 0);
    chk("br_after_commit_valid", 32'(bus.commit_valid), 0);

    // ---------------- two channels on one tag ----------------
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      alloc(ROB_T_REG, 5'(i), 32'h0, 1'b0, 1'b0, 32'h0);
      step();
    end
    idle();
    wb(0, 4'd5, 32'hA, 1'b0);
    wb(1, 4'd5, 32'hB, 1'b0);
    bus.rs1_tag = 4'd5;
    #1;
`ifdef ROB_BYPASS_EN
    chk("dual_bypass_ready", 32'(bus.rs1_ready), 1);
    chk("dual_bypass_value", bus.rs1_value, 32'hB);
`else
    chk("dual_nobypass_ready", 32'(bus.rs1_ready), 0);
`endif
    @(posedge clk);
    #1;
    bus.wb_valid = '0;
    #1;
    chk("dual_stored_ready", 32'(bus.rs1_ready), 1);
    chk("dual_stored_value", bus.rs1_value, 32'hB);

    // ---------------- flush, then rdy=0 hold ----------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      alloc(ROB_T_REG, 5'(i), 32'h0, 1'b0, 1'b0, 32'h0);
      step();
    end
    idle();
    wb(0, 4'd0, 32'h99, 1'b0);
    step();
    idle();
    flush = 1'b1;
    step();
    chk("flush_commit_valid", 32'(bus.commit_valid), 0);
    chk("flush_empty", 32'(bus.empty), 1);
    chk("flush_full", 32'(bus.full), 0);
    chk("flush_alloc_tag", 32'(bus.alloc_tag), 0);
    idle();
    alloc(ROB_T_REG, 5'd3, 32'h0, 1'b0, 1'b1, 32'h77);
    step();
    for (int i = 0; i < 3; i++) begin
      idle();
      rdy = 1'b0;
      alloc(ROB_T_REG, 5'd4, 32'h0, 1'b0, 1'b1, 32'h88);
      step();
      chk($sformatf("hold%0d_commit_valid", i), 32'(bus.commit_valid), 0);
      chk($sformatf("hold%0d_alloc_tag", i), 32'(bus.alloc_tag), 1);
      chk($sformatf("hold%0d_empty", i), 32'(bus.empty), 0);
    end
    idle();
    step();
    chk("hold_release_commit_valid", 32'(bus.commit_valid), 1);
    chk("hold_release_commit_value", bus.commit_value, 32'h77);
    chk("hold_release_empty", 32'(bus.empty), 1);

    // ---------------- randomized traffic vs program-order model ----------------
    do_reset();
    q.delete();
    ntag = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [1:0]  t;
      bit          r1, r2, com, was_full, e_cv, e_mis;
      logic [31:0] v1, v2;
      ment_t       ce, ne;
      idle();
      rdy   = ($urandom_range(15) != 0);
      flush = ($urandom_range(63) == 0);
      if ($urandom_range(3) != 0) begin
        t = ($urandom_range(7) == 0) ? ROB_T_BRANCH :
            (($urandom_range(3) == 0) ? ROB_T_STORE : ROB_T_REG);
        alloc(t, 5'($urandom_range(31)), $urandom, 1'($urandom_range(1)),
              (t == ROB_T_BRANCH) ? 1'b0 : 1'($urandom_range(3) == 0), $urandom);
      end
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(1) != 0) begin
          if (q.size() > 0 && $urandom_range(7) != 0)
            wb(ch, 4'(q[$urandom_range(q.size() - 1)].tag), $urandom, 1'($urandom_range(1)));
          else
            wb(ch, 4'($urandom_range(15)), $urandom, 1'($urandom_range(1)));
        end
      end
      bus.rs1_tag = (q.size() > 0) ? 4'(q[$urandom_range(q.size() - 1)].tag) : 4'($urandom_range(15));
      bus.rs2_tag = 4'($urandom_range(15));
      #1;
      model_lookup(bus.rs1_tag, r1, v1);
      model_lookup(bus.rs2_tag, r2, v2);
      chk("rnd_rs1_ready", 32'(bus.rs1_ready), 32'(r1));
      if (r1) chk("rnd_rs1_value", bus.rs1_value, v1);
      chk("rnd_rs2_ready", 32'(bus.rs2_ready), 32'(r2));
      if (r2) chk("rnd_rs2_value", bus.rs2_value, v2);

      e_cv = 1'b0; e_mis = 1'b0;
      if (rdy) begin
        if (flush) begin
          q.delete();
          ntag = 0;
        end else begin
          com      = (q.size() > 0) && q[0].done;
          was_full = (q.size() == 16);
          if (com) ce = q[0];
          for (int ch = 0; ch < 2; ch++) begin
            if (bus.wb_valid[ch]) begin
              foreach (q[k]) begin
                if (q[k].tag == int'(bus.wb_tag[ch*4 +: 4])) begin
                  q[k].done = 1'b1;
                  q[k].val  = bus.wb_value[ch*32 +: 32];
                  q[k].jump = bus.wb_jump[ch];
                end
              end
            end
          end
          if (com) begin
            e_cv = 1'b1;
            void'(q.pop_front());
            e_mis = (ce.typ == ROB_T_BRANCH) && (ce.pred != ce.jump);
          end
          if (e_mis) begin
            q.delete();
            ntag = 0;
          end else if (bus.alloc_valid && !was_full) begin
            ne.tag = ntag; ne.typ = bus.alloc_type; ne.rd = bus.alloc_rd;
            ne.pc = bus.alloc_pc; ne.pred = bus.alloc_pred; ne.done = bus.alloc_ready;
            ne.val = bus.alloc_value; ne.jump = 1'b0;
            q.push_back(ne);
            ntag = (ntag + 1) % 16;
          end
        end
      end

      @(posedge clk);
      #1;
      chk("rnd_commit_valid", 32'(bus.commit_valid), 32'(e_cv));
      if (e_cv) begin
        chk("rnd_commit_tag", 32'(bus.commit_tag), 32'(ce.tag));
        chk("rnd_commit_type", 32'(bus.commit_type), 32'(ce.typ));
        chk("rnd_commit_rd", 32'(bus.commit_rd), 32'(ce.rd));
        chk("rnd_commit_value", bus.commit_value, ce.val);
        chk("rnd_commit_pc", bus.commit_pc, ce.pc);
        chk("rnd_commit_jump", 32'(bus.commit_jump), 32'(ce.jump));
      end
      chk("rnd_mispredict", 32'(bus.mispredict), 32'(e_mis));
      if (e_mis) chk("rnd_redirect", bus.redirect_pc, ce.val);
      chk("rnd_full", 32'(bus.full), 32'(q.size() == 16));
      chk("rnd_empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("rnd_alloc_tag", 32'(bus.alloc_tag), 32'(ntag));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
